a2d_spi_master: RTL and testbench
=================================

// Module: a2d_spi_master
// PURPOSE
//  SPI monarch for the ADC128S 8-channel 12-bit A2D, feeding the slide-pot round-robin sequencer.
//  On strt_cnv it runs two 16-bit SPI transactions. The first sends the channel command; the second
//  sends it again and captures the conversion. It then pulses cnv_cmplt with res valid.
//  Sits between the sequencer (strt_cnv/chnnl/res/cnv_cmplt) and the board A2D pins.
// PARAMETERS
//  SCLK_DIV_W  5   SCLK divider width; SCLK period = 2^SCLK_DIV_W clk cycles (32 at default)
// PORTS
//  clk        in   1   system clock, single clock domain
//  rst        in   1   synchronous, active-high reset
//  strt_cnv   in   1   start conversion; honoured only in IDLE, ignored while busy
//  chnnl      in   3   A2D channel, captured on the accepted strt_cnv cycle
//  cnv_cmplt  out  1   1-clk pulse: res updated this cycle
//  res        out  12  last conversion result, held until the next cnv_cmplt
//  a2d_SS_n   out  1   A2D chip select, active low
//  SCLK       out  1   SPI clock, idles high
//  MOSI       out  1   SPI data to A2D
//  MISO       in   1   SPI data from A2D
// BEHAVIOUR
//  Reset (rst=1 at clk edge): a2d_SS_n=1, SCLK=1, MOSI=0, cnv_cmplt=0, res=12'h000, FSM=IDLE.
//  Reset mid-transaction aborts it; SS_n is high after that same edge; no cnv_cmplt is produced.
//  Top FSM: IDLE -(strt_cnv)-> TRANS1 -(spi_done)-> GAP (2 clk, SS_n=1) -> TRANS2 -(spi_done)-> DONE -> IDLE.
//  DONE lasts 1 clk: cnv_cmplt=1, and res takes shift[11:0] on the same edge.
//  strt_cnv asserted in DONE is ignored. It is accepted on the following IDLE cycle.
//  Command word, both transactions: {2'b00, chnnl_cap, 11'h000}, MSB first.
//  SPI engine (one 16-bit transaction):
//   - On start: SS_n goes low. The divider loads 5'b10111 (front porch). MOSI = cmd[15].
//   - SCLK = div[MSB]. The divider increments every clk while active.
//   - At div==all-ones (fall imminent), the shifter shifts left and MOSI takes the next bit.
//     Exception: the first pass (front porch) does not shift.
//   - At div==0b01111 (rise imminent), MISO is sampled into shift[0] with the shift.
//     A combined shift register is allowed.
//   - After the 16th sample, at the next div==all-ones the engine stops.
//     SS_n=1, SCLK stays high (no 17th fall), spi_done pulses 1 clk.
//   - Transaction length T = 16*2^W + 8 clk = 520 at default.
//  Latency: cnv_cmplt is high exactly 2T+3 clk after the strt_cnv cycle (1043 at default).
//  Back-to-back: strt_cnv on the cycle after cnv_cmplt starts a new conversion. There is no gap beyond IDLE's 1 clk.
//  Widths: the divider is SCLK_DIV_W bits and wraps naturally. The bit counter is 5 bits and saturates at 16.
//  All outputs are registered. SCLK and SS_n must be glitch-free.
// CONFIGURATION
//  A2D_RES_INV_EN defined: res = 12'hFFF - shift[11:0]. This gives slider-up = large value on the inverted pot wiring.
//  Undefined: res = shift[11:0] unmodified. Timing is identical in both builds.
// STRUCTURE
//  Package a2d_pkg:
//   - typedef enum {IDLE,TRANS1,GAP,TRANS2,DONE} a2d_state_t
//   - localparams CMD_PAD_HI=2'b00, CMD_PAD_LO=11'h000, GAP_CYCLES=2, SPI_BITS=16
//  Sub-module spi_mnrch16:
//   - ports clk, rst, wrt, wt_data[15:0], done, rd_data[15:0], SS_n, SCLK, MOSI, MISO
//   - owns the divider, shifter and bit counter; the top holds only the FSM and the res/cnv_cmplt regs.
// TESTING (bench uses a behavioural ADC128S model)
//  1. Reset:
//     rst held 3 clk -> SS_n=1, SCLK=1, cnv_cmplt=0, res=0.
//     strt_cnv during rst -> ignored.
//  2. Single conversion:
//     model ch3=12'hA5C; strt_cnv with chnnl=3 -> MOSI word 16'h1800 in both transactions.
//     cnv_cmplt at +1043 clk; res=12'hA5C (12'h5A3 with A2D_RES_INV_EN).
//  3. SPI timing:
//     SCLK period 32 clk; 16 falls per SS_n low window; SS_n low 520 clk; SS_n high 2 clk between transactions.
//     MISO sampled 1 clk before each rise.
//  4. Busy ignore:
//     strt_cnv re-pulsed at +100 with chnnl=5 -> result and command still for ch3; exactly one cnv_cmplt.
//  5. Round-robin back-to-back:
//     strt_cnv driven from cnv_cmplt delayed 1 clk; channels 0..4,7 with distinct values.
//     -> each res matches its channel; period 1045 clk.
//  6. Mid-op reset:
//     rst at +300 -> SS_n=1 next edge; no cnv_cmplt; res stays 0.
//     The next strt_cnv completes normally.

Source files
------------

// File: rtl/a2d_spi_master_pkg.sv
// Shared types and constants for the ADC128S SPI master.
// Optional build macro: A2D_RES_INV_EN (see a2d_spi_master.sv).
package a2d_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRANS1,
        GAP,
        TRANS2,
        DONE
    } a2d_state_t;

    localparam logic [1:0]  CMD_PAD_HI = 2'b00;
    localparam logic [10:0] CMD_PAD_LO = 11'h000;
    localparam int          GAP_CYCLES = 2;
    localparam int          SPI_BITS   = 16;

endpackage

// File: rtl/a2d_spi_master_if.sv
// Sequencer-side bundle: conversion request and result.
// master = sequencer, slave = A2D SPI master.
interface a2d_spi_master_if;

    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] res;

    modport master (
        output strt_cnv,
        output chnnl,
        input  cnv_cmplt,
        input  res
    );

    modport slave (
        input  strt_cnv,
        input  chnnl,
        output cnv_cmplt,
        output res
    );

endinterface

// File: rtl/a2d_spi_master_spi.sv
// 16-bit SPI engine: SCLK divider, combined MOSI/MISO shifter, bit counter.
// SCLK idles high; one transaction is 16*2^DIV_W + 8 clk of SS_n low.
module spi_mnrch16
    import a2d_pkg::*;
#(
    parameter int DIV_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wrt,
    input  logic [15:0] wt_data,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    localparam logic [DIV_W-1:0] DIV_ONES  = '1;
    localparam logic [DIV_W-1:0] DIV_PORCH = DIV_ONES - DIV_W'(8);
    localparam logic [DIV_W-1:0] DIV_RISE  = DIV_ONES >> 1;
    localparam logic [DIV_W-1:0] DIV_STOP  = DIV_ONES - DIV_W'(1);

    logic [DIV_W-1:0] div;
    logic [15:0]      shift;
    logic [4:0]       bit_cnt;
    logic             active;
    logic             rise_imm;
    logic             fall_imm;
    logic             last;

    assign rise_imm = (div == DIV_RISE);
    assign fall_imm = (div == DIV_ONES);
    assign last     = (bit_cnt == 5'(SPI_BITS));
    // Stop as div reaches all-ones so SCLK parks high without a 17th fall
    assign done     = active & last & (div == DIV_STOP);
    assign SCLK     = div[DIV_W-1];
    assign rd_data  = shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            active  <= 1'b0;
            SS_n    <= 1'b1;
            div     <= DIV_ONES;
            shift   <= '0;
            bit_cnt <= '0;
            MOSI    <= 1'b0;
        end else if (!active) begin
            if (wrt) begin
                active  <= 1'b1;
                SS_n    <= 1'b0;
                div     <= DIV_PORCH;
                shift   <= wt_data;
                bit_cnt <= '0;
                MOSI    <= wt_data[15];
            end
        end else if (done) begin
            active <= 1'b0;
            SS_n   <= 1'b1;
            div    <= DIV_ONES;
        end else begin
            div <= div + DIV_W'(1);
            if (rise_imm && !last) begin
                shift   <= {shift[14:0], MISO};
                bit_cnt <= bit_cnt + 5'd1;
            end
            if (fall_imm && !last) begin
                MOSI <= shift[15];
            end
        end
    end

endmodule

// File: rtl/a2d_spi_master.sv
// ADC128S conversion sequencer: two SPI transactions per request.
// Define A2D_RES_INV_EN to report 12'hFFF - sample for inverted pot wiring.
module a2d_spi_master
    import a2d_pkg::*;
#(
    parameter int SCLK_DIV_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    a2d_spi_master_if.slave  bus,
    output logic             a2d_SS_n,
    output logic             SCLK,
    output logic             MOSI,
    input  logic             MISO
);

    localparam logic [1:0] GAP_LAST = 2'(GAP_CYCLES - 2);

    a2d_state_t  state;
    logic [2:0]  chnnl_cap;
    logic        wrt;
    logic [1:0]  gap_cnt;
    logic        spi_done;
    logic [15:0] rd_data;
    logic [15:0] cmd;
    logic [11:0] res_nxt;
    logic        cnv_cmplt_q;
    logic [11:0] res_q;
    logic        unused_rd;

    assign cmd       = {CMD_PAD_HI, chnnl_cap, CMD_PAD_LO};
    assign unused_rd = ^rd_data[15:12];

`ifdef A2D_RES_INV_EN
    assign res_nxt = 12'hFFF - rd_data[11:0];
`else
    assign res_nxt = rd_data[11:0];
`endif

    assign bus.cnv_cmplt = cnv_cmplt_q;
    assign bus.res       = res_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            chnnl_cap   <= '0;
            wrt         <= 1'b0;
            gap_cnt     <= '0;
            cnv_cmplt_q <= 1'b0;
            res_q       <= '0;
        end else begin
            wrt         <= 1'b0;
            cnv_cmplt_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.strt_cnv) begin
                        chnnl_cap <= bus.chnnl;
                        wrt       <= 1'b1;
                        state     <= TRANS1;
                    end
                end
                TRANS1: begin
                    if (spi_done) begin
                        gap_cnt <= '0;
                        state   <= GAP;
                    end
                end
                // The registered wrt supplies the last SS_n-high clock
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        wrt   <= 1'b1;
                        state <= TRANS2;
                    end else begin
                        gap_cnt <= gap_cnt + 2'd1;
                    end
                end
                TRANS2: begin
                    if (spi_done) begin
                        cnv_cmplt_q <= 1'b1;
                        res_q       <= res_nxt;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    spi_mnrch16 #(
        .DIV_W (SCLK_DIV_W)
    ) u_spi (
        .clk     (clk),
        .rst     (rst),
        .wrt     (wrt),
        .wt_data (cmd),
        .done    (spi_done),
        .rd_data (rd_data),
        .SS_n    (a2d_SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO)
    );

endmodule

// File: tb/tb_a2d_spi_master.sv
// Bench for a2d_spi_master with a behavioural ADC128S and a result scoreboard.
// Honours A2D_RES_INV_EN for the expected result mapping.
module tb_a2d_spi_master;
    import a2d_pkg::*;

    localparam int T_TRANS = 520;
    localparam int LAT     = 2 * T_TRANS + 3;
    localparam int PERIOD  = LAT + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a2d_SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO = 1'b0;

    a2d_spi_master_if bus();

    a2d_spi_master dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .a2d_SS_n (a2d_SS_n),
        .SCLK     (SCLK),
        .MOSI     (MOSI),
        .MISO     (MISO)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h, required %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [11:0] exp_res(input logic [11:0] v);
`ifdef A2D_RES_INV_EN
        return 12'hFFF - v;
`else
        return v;
`endif
    endfunction

    // ADC128S model plus SPI pin timing monitor, sampled mid-cycle
    logic [11:0] adc_val [8];
    logic [2:0]  adc_ch = 3'd0;
    logic [15:0] adc_out = 16'h0;
    logic [15:0] adc_rx = 16'h0;
    int          adc_bits = 0;
    logic        ss_prev = 1'b1;
    logic        sclk_prev = 1'b1;
    int unsigned ss_fall_cyc = 0;
    int unsigned ss_rise_cyc = 0;
    int unsigned last_fall = 0;
    int          falls = 0;
    int          txn_cnt = 0;
    logic [15:0] exp_cmd = 16'h0;

    always @(negedge clk) begin
        if (ss_prev && !a2d_SS_n) begin
            adc_out  = {4'h0, adc_val[adc_ch]};
            adc_rx   = '0;
            adc_bits = 0;
            falls    = 0;
            if (txn_cnt[0])
                check("ss_gap", cyc - ss_rise_cyc, GAP_CYCLES);
            ss_fall_cyc = cyc;
        end
        if (!a2d_SS_n && sclk_prev && !SCLK) begin
            if (falls > 0) check("sclk_period", cyc - last_fall, 32);
            last_fall = cyc;
            falls++;
            MISO    = adc_out[15];
            adc_out = {adc_out[14:0], 1'b0};
        end
        if (!a2d_SS_n && !sclk_prev && SCLK) begin
            adc_rx = {adc_rx[14:0], MOSI};
            adc_bits++;
        end
        if (!ss_prev && a2d_SS_n) begin
            ss_rise_cyc = cyc;
            if (adc_bits == 16) begin
                check("ss_low_len", cyc - ss_fall_cyc, T_TRANS);
                check("sclk_falls", falls, 16);
                check("mosi_word", adc_rx, exp_cmd);
                adc_ch = adc_rx[13:11];
                txn_cnt++;
            end else begin
                txn_cnt = 0;
            end
        end
        if (rst) txn_cnt = 0;
        ss_prev   = a2d_SS_n;
        sclk_prev = SCLK;
    end

    // Scoreboard: expectations pushed at accepted start, popped on cnv_cmplt
    typedef struct {
        logic [11:0] res;
        int unsigned start;
    } exp_t;

    exp_t        sb[$];
    int unsigned cmplt_cnt = 0;

    always @(negedge clk) begin
        if (bus.cnv_cmplt === 1'b1) begin
            exp_t e;
            cmplt_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_cmplt: actual res %0h, required no completion",
                         bus.res);
            end else begin
                e = sb.pop_front();
                check("res", bus.res, e.res);
                check("latency", cyc - e.start, LAT);
            end
        end
    end

    task automatic start_conv(input logic [2:0] ch, input bit accept);
        exp_t e;
        bus.chnnl    = ch;
        bus.strt_cnv = 1'b1;
        exp_cmd      = {2'b00, ch, 11'h000};
        if (accept) begin
            e.res   = exp_res(adc_val[ch]);
            e.start = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.strt_cnv = 1'b0;
    endtask

    task automatic wait_cmplt();
        int n = 0;
        while (bus.cnv_cmplt !== 1'b1 && n < 1200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 1200) begin
            errors++;
            $display("FAIL cmplt_timeout: actual none after %0d clk, required cnv_cmplt", n);
        end
    endtask

    typedef struct {
        logic [2:0]  ch;
        logic [11:0] val;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int unsigned c0;
        int unsigned prev_cmplt;

        vecs[0] = '{3'd0, 12'h123, exp_res(12'h123)};
        vecs[1] = '{3'd1, 12'hFED, exp_res(12'hFED)};
        vecs[2] = '{3'd2, 12'h800, exp_res(12'h800)};
        vecs[3] = '{3'd3, 12'hA5C, exp_res(12'hA5C)};
        vecs[4] = '{3'd4, 12'h001, exp_res(12'h001)};
        vecs[5] = '{3'd7, 12'h7FF, exp_res(12'h7FF)};
        adc_val[5] = 12'h3C3;
        adc_val[6] = 12'h6E6;
        for (int i = 0; i < 6; i++) adc_val[vecs[i].ch] = vecs[i].val;

        // Reset, with a start request that must be ignored
        rst          = 1'b1;
        bus.strt_cnv = 1'b1;
        bus.chnnl    = 3'd6;
        repeat (3) @(negedge clk);
        check("rst_ss_n", a2d_SS_n, 1'b1);
        check("rst_sclk", SCLK, 1'b1);
        check("rst_mosi", MOSI, 1'b0);
        check("rst_cmplt", bus.cnv_cmplt, 1'b0);
        check("rst_res", bus.res, 12'h000);
        rst          = 1'b0;
        bus.strt_cnv = 1'b0;
        repeat (5) @(negedge clk);
        check("post_rst_idle", a2d_SS_n, 1'b1);
        check("post_rst_no_cmplt", cmplt_cnt, 0);

        // Single conversion on channel 3
        start_conv(3'd3, 1'b1);
        wait_cmplt();
        check("single_res", bus.res, vecs[3].exp);
        @(negedge clk);
        check("cmplt_pulse", bus.cnv_cmplt, 1'b0);
        check("res_hold", bus.res, vecs[3].exp);

        // Start request while busy is ignored
        repeat (3) @(negedge clk);
        c0 = cmplt_cnt;
        start_conv(3'd3, 1'b1);
        repeat (98) @(negedge clk);
        bus.chnnl    = 3'd5;
        bus.strt_cnv = 1'b1;
        @(negedge clk);
        bus.strt_cnv = 1'b0;
        bus.chnnl    = 3'd0;
        wait_cmplt();
        repeat (1200) @(negedge clk);
        check("busy_one_cmplt", cmplt_cnt - c0, 1);
        check("busy_res", bus.res, vecs[3].exp);

        // Back-to-back round robin from the vector table
        prev_cmplt = 0;
        start_conv(vecs[0].ch, 1'b1);
        for (int i = 0; i < 6; i++) begin
            wait_cmplt();
            check("rr_res", bus.res, vecs[i].exp);
            if (i > 0) check("rr_period", cyc - prev_cmplt, PERIOD);
            prev_cmplt = cyc;
            if (i < 5) begin
                @(negedge clk);
                start_conv(vecs[i+1].ch, 1'b1);
            end
        end

        // Reset in the middle of the first transaction
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("clr_res", bus.res, 12'h000);
        c0 = cmplt_cnt;
        start_conv(3'd2, 1'b0);
        repeat (298) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ss_n", a2d_SS_n, 1'b1);
        check("abort_sclk", SCLK, 1'b1);
        rst = 1'b0;
        repeat (1200) @(negedge clk);
        check("abort_no_cmplt", cmplt_cnt - c0, 0);
        check("abort_res", bus.res, 12'h000);
        start_conv(3'd4, 1'b1);
        wait_cmplt();
        check("recover_res", bus.res, vecs[4].exp);
        repeat (5) @(negedge clk);
        check("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual still running, required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
